// File: rtl/usb_bulk_mux_if.sv
// Stream bundle for usb_bulk_mux: N AXI-stream sources in, one USB bulk-in stream out.
// The master modport is the mux side; the slave modport is the surrounding producers/USB core.
interface usb_bulk_mux_if #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 8
);
    localparam int KEEP = WIDTH / 8;

    logic [CHANNELS-1:0]      s_tvalid;
    logic [CHANNELS-1:0]      s_tready;
    logic [CHANNELS-1:0]      s_tlast;
    logic [CHANNELS*KEEP-1:0] s_tkeep;
    logic [CHANNELS*WIDTH-1:0] s_tdata;
    logic                     m_tvalid;
    logic                     m_tready;
    logic                     m_tlast;
    logic [KEEP-1:0]          m_tkeep;
    logic [WIDTH-1:0]         m_tdata;

    modport master (
        input  s_tvalid, s_tlast, s_tkeep, s_tdata, m_tready,
        output s_tready, m_tvalid, m_tlast, m_tkeep, m_tdata
    );

    modport slave (
        output s_tvalid, s_tlast, s_tkeep, s_tdata, m_tready,
        input  s_tready, m_tvalid, m_tlast, m_tkeep, m_tdata
    );
endinterface

// File: rtl/usb_bulk_mux.sv
// Round-robin packet arbiter merging N AXI-stream sources into the USB bulk-in stream,
// with optional channel-tag header beat and splitting of long packets into continuations.
module usb_bulk_mux #(
    parameter int CHANNELS   = 2,
    parameter int WIDTH      = 8,
    parameter int HEADER     = 1,
    parameter int MAX_LENGTH = 512
) (
    input  logic               clock,
    input  logic               reset,
    usb_bulk_mux_if.master     bus,
    output logic [3:0]         grant_o,
    output logic               busy_o
);
    localparam int KEEP = WIDTH / 8;
    localparam int CW   = $clog2(MAX_LENGTH) + 1;
    localparam logic [CW-1:0] LIMIT = CW'(MAX_LENGTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [3:0]          grant_r, grant_nxt_s;
    logic [CHANNELS-1:0] cont_r, cont_nxt_s;
    logic [CW-1:0]       count_r, count_nxt_s;
    logic [WIDTH-1:0]    head_r, head_nxt_s;
    logic                busy_r;

    logic [CHANNELS-1:0] grant_oh_s;
    logic                sel_valid_s;
    logic                sel_last_s;
    logic [KEEP-1:0]     sel_keep_s;
    logic [WIDTH-1:0]    sel_data_s;

    logic                win_found_s;
    logic [3:0]          win_idx_s;
    logic                win_cont_s;
    logic                xfer_s;
    logic                at_limit_s;

    // Mux the granted channel's stream signals (AND-OR select, no priority).
    always_comb begin
        grant_oh_s  = '0;
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        sel_keep_s  = '0;
        sel_data_s  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            grant_oh_s[c] = (grant_r == 4'(c));
            sel_valid_s   = sel_valid_s | (bus.s_tvalid[c] & grant_oh_s[c]);
            sel_last_s    = sel_last_s  | (bus.s_tlast[c]  & grant_oh_s[c]);
            sel_keep_s    = sel_keep_s  | (bus.s_tkeep[c*KEEP +: KEEP]   & {KEEP{grant_oh_s[c]}});
            sel_data_s    = sel_data_s  | (bus.s_tdata[c*WIDTH +: WIDTH] & {WIDTH{grant_oh_s[c]}});
        end
    end

    // Round-robin search starting one past the last grant; first requester wins.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = grant_r;
        win_cont_s  = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            int   cand;
            logic hit;
            cand        = (int'(grant_r) + 1 + i) % CHANNELS;
            hit         = bus.s_tvalid[cand] & ~win_found_s;
            win_idx_s   = hit ? 4'(cand) : win_idx_s;
            win_cont_s  = hit ? cont_r[cand] : win_cont_s;
            win_found_s = win_found_s | hit;
        end
    end

    assign xfer_s     = sel_valid_s & bus.m_tready;
    assign at_limit_s = (count_r == LIMIT);

    // Next-state logic and stream outputs; DATA is a zero-latency pass-through.
    always_comb begin
        state_nxt_s  = state_r;
        grant_nxt_s  = grant_r;
        cont_nxt_s   = cont_r;
        count_nxt_s  = count_r;
        head_nxt_s   = head_r;
        bus.s_tready = '0;
        bus.m_tvalid = 1'b0;
        bus.m_tlast  = 1'b0;
        bus.m_tkeep  = '0;
        bus.m_tdata  = '0;
        case (state_r)
            IDLE: begin
                if (win_found_s) begin
                    grant_nxt_s     = win_idx_s;
                    count_nxt_s     = '0;
                    head_nxt_s      = '0;
                    head_nxt_s[7:0] = {win_cont_s, 3'b000, win_idx_s};
                    state_nxt_s     = (HEADER != 0) ? HEAD : DATA;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            HEAD: begin
                bus.m_tvalid = 1'b1;
                bus.m_tkeep  = '1;
                bus.m_tdata  = head_r;
                if (bus.m_tready) begin
                    count_nxt_s = CW'(1);
                    state_nxt_s = DATA;
                end else begin
                    state_nxt_s = HEAD;
                end
            end
            DATA: begin
                bus.m_tvalid = sel_valid_s;
                bus.m_tdata  = sel_data_s;
                bus.m_tkeep  = sel_keep_s;
                bus.m_tlast  = sel_valid_s & (sel_last_s | at_limit_s);
                bus.s_tready = grant_oh_s & {CHANNELS{bus.m_tready}};
                if (xfer_s) begin
                    count_nxt_s = count_r + CW'(1);
                    if (sel_last_s | at_limit_s) begin
                        // A source tlast on the limit beat is a normal end, not a split.
                        cont_nxt_s  = sel_last_s ? (cont_r & ~grant_oh_s) : (cont_r | grant_oh_s);
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = DATA;
                    end
                end else begin
                    state_nxt_s = DATA;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, grant, continuation flags, beat counter and registered header beat.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            grant_r <= 4'(CHANNELS - 1);
            cont_r  <= '0;
            count_r <= '0;
            head_r  <= '0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            grant_r <= grant_nxt_s;
            cont_r  <= cont_nxt_s;
            count_r <= count_nxt_s;
            head_r  <= head_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
        end
    end

    assign grant_o = grant_r;
    assign busy_o  = busy_r;
endmodule

// File: tb/tb_usb_bulk_mux.sv
// Bench for usb_bulk_mux: two instances (header/512 and no-header/4) against a packet-level model.
module tb_usb_bulk_mux;
    localparam int W     = 16;
    localparam int K     = 2;
    localparam int DEPTH = 2048;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] grant_a, grant_b;
    logic       busy_a, busy_b;

    always #5 clock = ~clock;

    usb_bulk_mux_if #(.CHANNELS(2), .WIDTH(W)) bus_a ();
    usb_bulk_mux_if #(.CHANNELS(2), .WIDTH(W)) bus_b ();

    usb_bulk_mux #(.CHANNELS(2), .WIDTH(W), .HEADER(1), .MAX_LENGTH(512)) dut_a (
        .clock(clock), .reset(reset), .bus(bus_a), .grant_o(grant_a), .busy_o(busy_a));
    usb_bulk_mux #(.CHANNELS(2), .WIDTH(W), .HEADER(0), .MAX_LENGTH(4)) dut_b (
        .clock(clock), .reset(reset), .bus(bus_b), .grant_o(grant_b), .busy_o(busy_b));

    int checks = 0;
    int errors = 0;

    // Per instance u, per channel c: queued source beats.
    logic [W-1:0] md [2][2][DEPTH];
    logic [K-1:0] mk [2][2][DEPTH];
    logic         ml [2][2][DEPTH];
    int           wp [2][2];
    int           rp [2][2];

    // Packet-level reference state.
    int           hd [2];
    int           mx [2];
    bit           busy [2];
    bit           hdr  [2];
    int           g    [2];
    int           lg   [2];
    int           left [2];
    logic [W-1:0] hbyte [2];
    bit           cont [2][2];

    bit sv  [2][2];
    bit rdy [2];
    bit gap_en;
    int rdy_mode;
    int tog;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int u, input int c, input logic [W-1:0] d, input logic [K-1:0] k, input bit l);
        md[u][c][wp[u][c]] = d;
        mk[u][c][wp[u][c]] = k;
        ml[u][c][wp[u][c]] = l;
        wp[u][c]++;
    endtask

    task automatic push_pkt(input int u, input int c, input int len, input int base, input logic [K-1:0] lastk);
        for (int i = 0; i < len; i++)
            push(u, c, W'(base + i), (i == len - 1) ? lastk : 2'b11, i == len - 1);
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            busy[u] = 1'b0; hdr[u] = 1'b0; left[u] = 0; lg[u] = 1; g[u] = 0;
            for (int c = 0; c < 2; c++) begin
                cont[u][c] = 1'b0; rp[u][c] = 0; wp[u][c] = 0; sv[u][c] = 1'b0;
            end
        end
    endtask

    task automatic drive();
        bus_a.s_tvalid = {sv[0][1], sv[0][0]};
        bus_a.s_tlast  = {ml[0][1][rp[0][1]], ml[0][0][rp[0][0]]};
        bus_a.s_tkeep  = {mk[0][1][rp[0][1]], mk[0][0][rp[0][0]]};
        bus_a.s_tdata  = {md[0][1][rp[0][1]], md[0][0][rp[0][0]]};
        bus_a.m_tready = rdy[0];
        bus_b.s_tvalid = {sv[1][1], sv[1][0]};
        bus_b.s_tlast  = {ml[1][1][rp[1][1]], ml[1][0][rp[1][0]]};
        bus_b.s_tkeep  = {mk[1][1][rp[1][1]], mk[1][0][rp[1][0]]};
        bus_b.s_tdata  = {md[1][1][rp[1][1]], md[1][0][rp[1][0]]};
        bus_b.m_tready = rdy[1];
    endtask

    task automatic check_outputs();
        for (int u = 0; u < 2; u++) begin
            logic         ov, ol, ob, ev, el;
            logic [K-1:0] ok, ek;
            logic [W-1:0] od, ed;
            logic [1:0]   ordy, er;
            logic [3:0]   og;
            string        nm;
            nm = (u == 0) ? "a" : "b";
            if (u == 0) begin
                ov = bus_a.m_tvalid; ol = bus_a.m_tlast; ok = bus_a.m_tkeep; od = bus_a.m_tdata;
                ordy = bus_a.s_tready; ob = busy_a; og = grant_a;
            end else begin
                ov = bus_b.m_tvalid; ol = bus_b.m_tlast; ok = bus_b.m_tkeep; od = bus_b.m_tdata;
                ordy = bus_b.s_tready; ob = busy_b; og = grant_b;
            end
            ev = 1'b0; el = 1'b0; ek = '0; ed = '0; er = '0;
            if (busy[u] && hdr[u]) begin
                ev = 1'b1; ed = hbyte[u]; ek = 2'b11;
            end else if (busy[u]) begin
                ev = sv[u][g[u]];
                er[g[u]] = rdy[u];
                ed = md[u][g[u]][rp[u][g[u]]];
                ek = mk[u][g[u]][rp[u][g[u]]];
                el = ev && (left[u] == 1);
            end
            chk({nm, ".m_tvalid"}, 32'(ov), 32'(ev));
            chk({nm, ".s_tready"}, 32'(ordy), 32'(er));
            chk({nm, ".m_tlast"}, 32'(ol), 32'(el));
            chk({nm, ".busy_o"}, 32'(ob), 32'(busy[u]));
            chk({nm, ".grant_o"}, 32'(og), 32'(lg[u]));
            if (ev || !busy[u]) begin
                chk({nm, ".m_tdata"}, 32'(od), 32'(ed));
                chk({nm, ".m_tkeep"}, 32'(ok), 32'(ek));
            end
        end
    endtask

    // Effect of the coming rising edge: handshakes, piece bookkeeping, arbitration.
    task automatic update_model();
        for (int u = 0; u < 2; u++) begin
            if (busy[u]) begin
                if (hdr[u]) begin
                    if (rdy[u]) hdr[u] = 1'b0;
                end else if (sv[u][g[u]] && rdy[u]) begin
                    rp[u][g[u]]++;
                    left[u]--;
                    if (left[u] == 0) busy[u] = 1'b0;
                end
            end else begin
                bit found = 1'b0;
                for (int k = 1; k <= 2; k++) begin
                    int c = (lg[u] + k) % 2;
                    if (!found && sv[u][c]) begin
                        int p = rp[u][c];
                        int n, cap;
                        found = 1'b1;
                        while (p < wp[u][c] && !ml[u][c][p]) p++;
                        n        = p - rp[u][c] + 1;
                        cap      = mx[u] - hd[u];
                        left[u]  = (n < cap) ? n : cap;
                        hbyte[u] = W'({cont[u][c], 3'b000, 4'(c)});
                        cont[u][c] = (n > cap);
                        busy[u]  = 1'b1;
                        hdr[u]   = (hd[u] != 0);
                        g[u]     = c;
                        lg[u]    = c;
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clock);
        for (int u = 0; u < 2; u++) begin
            rdy[u] = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ($urandom_range(0, 1) == 1) : (tog % 2 == 0);
            for (int c = 0; c < 2; c++)
                sv[u][c] = (rp[u][c] < wp[u][c]) && (!gap_en || $urandom_range(0, 3) != 0);
        end
        tog++;
        drive();
        #1;
        check_outputs();
        update_model();
    endtask

    function automatic bit all_idle();
        for (int u = 0; u < 2; u++) begin
            if (busy[u]) return 1'b0;
            for (int c = 0; c < 2; c++)
                if (rp[u][c] != wp[u][c]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drain(input int maxc);
        int n = 0;
        while (!all_idle() && n < maxc) begin
            cycle();
            n++;
        end
        chk("drain_timeout", 32'(n < maxc), 32'd1);
        cycle();
        cycle();
        for (int u = 0; u < 2; u++)
            for (int c = 0; c < 2; c++) begin
                rp[u][c] = 0; wp[u][c] = 0;
            end
    endtask

    initial begin
        hd[0] = 1; mx[0] = 512;
        hd[1] = 0; mx[1] = 4;
        for (int u = 0; u < 2; u++)
            for (int c = 0; c < 2; c++)
                for (int i = 0; i < DEPTH; i++) begin
                    md[u][c][i] = '0; mk[u][c][i] = '0; ml[u][c][i] = 1'b0;
                end
        model_reset();
        rdy_mode = 0; gap_en = 1'b0; tog = 0;
        rdy[0] = 1'b1; rdy[1] = 1'b1;
        drive();

        // Reset state.
        repeat (3) @(negedge clock);
        #1;
        check_outputs();
        @(negedge clock);
        reset = 1'b0;

        // Single packet on ch0; 6-beat partial-keep packet on b.
        push(0, 0, 16'h0011, 2'b11, 1'b0);
        push(0, 0, 16'h0022, 2'b11, 1'b0);
        push(0, 0, 16'h0033, 2'b11, 1'b0);
        push(0, 0, 16'h0044, 2'b11, 1'b1);
        push_pkt(1, 0, 6, 16'h0a00, 2'b01);
        drain(100);

        // Both channels continuously valid: round-robin alternation.
        for (int u = 0; u < 2; u++)
            for (int r = 0; r < 2; r++)
                for (int c = 0; c < 2; c++)
                    push_pkt(u, c, 3, 16'h1000 * (c + 1) + 16 * r, 2'b11);
        drain(200);

        // Long packet split into 511 + 89, then a fresh packet on the same channel.
        push_pkt(0, 1, 600, 16'h2000, 2'b11);
        push_pkt(0, 1, 2, 16'h3000, 2'b11);
        push_pkt(1, 1, 9, 16'h4000, 2'b10);
        drain(2000);

        // Toggling ready plus source gaps.
        rdy_mode = 2; gap_en = 1'b1;
        for (int u = 0; u < 2; u++)
            for (int c = 0; c < 2; c++)
                push_pkt(u, c, 7, 16'h5000 + 16'h100 * c, 2'b01);
        drain(500);

        // Randomised traffic.
        rdy_mode = 1;
        for (int r = 0; r < 40; r++)
            for (int u = 0; u < 2; u++)
                for (int c = 0; c < 2; c++)
                    if ($urandom_range(0, 3) != 0)
                        push_pkt(u, c, int'($urandom_range(1, 20)), int'($urandom_range(0, 16'hffff)),
                                 ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b11);
        drain(20000);

        // Reset in the middle of a packet.
        rdy_mode = 0; gap_en = 1'b0;
        push_pkt(0, 0, 8, 16'h6000, 2'b11);
        repeat (5) cycle();
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rst.m_tvalid", 32'(bus_a.m_tvalid), 32'd0);
        chk("rst.m_tdata", 32'(bus_a.m_tdata), 32'd0);
        chk("rst.m_tkeep", 32'(bus_a.m_tkeep), 32'd0);
        chk("rst.m_tlast", 32'(bus_a.m_tlast), 32'd0);
        chk("rst.s_tready", 32'(bus_a.s_tready), 32'd0);
        chk("rst.busy_o", 32'(busy_a), 32'd0);
        chk("rst.grant_o", 32'(grant_a), 32'd1);
        model_reset();
        drive();
        @(negedge clock);
        reset = 1'b0;
        for (int u = 0; u < 2; u++)
            for (int c = 0; c < 2; c++)
                push_pkt(u, c, 5, 16'h7000 + 16'h100 * c, 2'b11);
        drain(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
